// File: rtl/mbldcm_ramp_phase_controller.sv
// rtl/mbldcm_ramp_phase_controller.sv - BLDC commutation sequencer with direction control and soft-start/soft-stop ramp
module mbldcm_ramp_phase_controller #(
    parameter int pDivWidth         = 32,
    parameter int pPhaseWidth       = 3,
    parameter int pTotalPhaseStages = 6,
    parameter int pStepWidth        = 16
) (
    input  logic                   iClock,
    input  logic                   iReset_n,
    input  logic                   iEnable,
    input  logic                   iDir,
    input  logic [pDivWidth-1:0]   iStartDiv,
    input  logic [pDivWidth-1:0]   iTargetDiv,
    input  logic [pStepWidth-1:0]  iRampStep,
    input  logic [pPhaseWidth-1:0] iPhaseUpdate,
    input  logic                   iLatchPhaseUpdate,
    output logic [pPhaseWidth-1:0] oPhase,
    output logic [pDivWidth-1:0]   oCurDiv,
    output logic [1:0]             oState,
    output logic                   oCommutate,
    output logic                   oAtSpeed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        DECEL = 2'd3
    } stateT;

    localparam logic [pDivWidth-1:0]   kDivOne    = pDivWidth'(1);
    localparam logic [pPhaseWidth-1:0] kPhaseOne  = pPhaseWidth'(1);
    localparam logic [pPhaseWidth-1:0] kLastPhase = pPhaseWidth'(pTotalPhaseStages - 1);

    stateT                  state;
    stateT                  stateNext;
    logic [pPhaseWidth-1:0] phase;
    logic [pPhaseWidth-1:0] phaseNext;
    logic [pDivWidth-1:0]   curDiv;
    logic [pDivWidth-1:0]   curDivNext;
    logic [pDivWidth-1:0]   counter;
    logic [pDivWidth-1:0]   counterNext;
    logic                   commutate;
    logic                   commutateNext;

    logic [pDivWidth-1:0]   satStart;
    logic [pDivWidth-1:0]   satTarget;
    logic [pDivWidth-1:0]   slewGoal;
    logic [pDivWidth-1:0]   slewed;
    logic [pDivWidth:0]     curExt;
    logic [pDivWidth:0]     goalExt;
    logic [pDivWidth:0]     stepExt;
    logic [pDivWidth:0]     slewedExt;
    logic                   tick;

    // Zero dividers would stall the timer, so they are treated as one clock.
    always_comb begin
        satStart  = (iStartDiv  == '0) ? kDivOne : iStartDiv;
        satTarget = (iTargetDiv == '0) ? kDivOne : iTargetDiv;
    end

    // Slew one step toward the goal of the current state; one extra bit keeps the compares from wrapping.
    always_comb begin
        slewGoal  = (state == DECEL) ? satStart : satTarget;
        curExt    = {1'b0, curDiv};
        goalExt   = {1'b0, slewGoal};
        stepExt   = (pDivWidth + 1)'(iRampStep);
        slewedExt = goalExt;
        if (iRampStep == '0) begin
            slewedExt = goalExt;
        end else if (curExt > goalExt + stepExt) begin
            slewedExt = curExt - stepExt;
        end else if (curExt + stepExt < goalExt) begin
            slewedExt = curExt + stepExt;
        end
        slewed = slewedExt[pDivWidth-1:0];
    end

    // Sequencer next-state, interval timer reload and phase stepping.
    always_comb begin
        stateNext     = state;
        curDivNext    = curDiv;
        counterNext   = counter;
        phaseNext     = phase;
        tick          = (counter == '0) && (state != IDLE);
        commutateNext = tick && !iLatchPhaseUpdate;

        if (state == IDLE) begin
            counterNext = '0;
            if (iEnable) begin
                stateNext   = RAMP;
                curDivNext  = satStart;
                counterNext = satStart - kDivOne;
            end
        end else begin
            if (tick) begin
                curDivNext  = slewed;
                counterNext = slewed - kDivOne;
            end else begin
                counterNext = counter - kDivOne;
            end

            case (state)
                RAMP: begin
                    if (!iEnable) begin
                        stateNext = DECEL;
                    end else if (tick && (slewed == satTarget)) begin
                        stateNext = RUN;
                    end
                end
                RUN: begin
                    if (!iEnable) begin
                        stateNext = DECEL;
                    end
                end
                DECEL: begin
                    if (iEnable) begin
                        stateNext = RAMP;
                    end else if (tick && (slewed == satStart)) begin
                        stateNext   = IDLE;
                        counterNext = '0;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end

        // A forced phase load wins over the timer advance but leaves the interval running.
        if (iLatchPhaseUpdate) begin
            phaseNext = (iPhaseUpdate > kLastPhase) ? kLastPhase : iPhaseUpdate;
        end else if (tick) begin
            if (iDir) begin
                phaseNext = (phase == '0) ? kLastPhase : phase - kPhaseOne;
            end else begin
                phaseNext = (phase == kLastPhase) ? '0 : phase + kPhaseOne;
            end
        end
    end

    // State, timer, divider, phase and commutation pulse registers.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state     <= IDLE;
            phase     <= '0;
            curDiv    <= '0;
            counter   <= '0;
            commutate <= 1'b0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            curDiv    <= curDivNext;
            counter   <= counterNext;
            commutate <= commutateNext;
        end
    end

    // At-speed flag compares against the raw target so a CSR change drops it immediately.
    always_comb begin
        oAtSpeed = (state == RUN) && (curDiv == iTargetDiv);
    end

    assign oPhase     = phase;
    assign oCurDiv    = curDiv;
    assign oState     = state;
    assign oCommutate = commutate;

endmodule

// File: tb/tb_mbldcm_ramp_phase_controller.sv
// tb/tb_mbldcm_ramp_phase_controller.sv - directed self-checking bench for mbldcm_ramp_phase_controller
module tb_mbldcm_ramp_phase_controller;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic        iEnable;
    logic        iDir;
    logic [31:0] iStartDiv;
    logic [31:0] iTargetDiv;
    logic [15:0] iRampStep;
    logic [2:0]  iPhaseUpdate;
    logic        iLatchPhaseUpdate;
    logic [2:0]  oPhase;
    logic [31:0] oCurDiv;
    logic [1:0]  oState;
    logic        oCommutate;
    logic        oAtSpeed;

    int checks = 0;
    int errors = 0;

    mbldcm_ramp_phase_controller #(
        .pDivWidth(32),
        .pPhaseWidth(3),
        .pTotalPhaseStages(6),
        .pStepWidth(16)
    ) dut (
        .iClock(iClock),
        .iReset_n(iReset_n),
        .iEnable(iEnable),
        .iDir(iDir),
        .iStartDiv(iStartDiv),
        .iTargetDiv(iTargetDiv),
        .iRampStep(iRampStep),
        .iPhaseUpdate(iPhaseUpdate),
        .iLatchPhaseUpdate(iLatchPhaseUpdate),
        .oPhase(oPhase),
        .oCurDiv(oCurDiv),
        .oState(oState),
        .oCommutate(oCommutate),
        .oAtSpeed(oAtSpeed)
    );

    always #5 iClock = ~iClock;

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitComm(input int maxCycles, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((oCommutate !== 1'b1) && (n < maxCycles));
    endtask

    initial begin
        int n;
        int seen;
        logic [2:0] fwdPhases [5];
        logic [2:0] revPhases [4];
        fwdPhases = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        revPhases = '{3'd0, 3'd5, 3'd4, 3'd3};

        iReset_n = 1'b0;
        iEnable = 1'b0;
        iDir = 1'b0;
        iStartDiv = 32'd10;
        iTargetDiv = 32'd4;
        iRampStep = 16'd3;
        iPhaseUpdate = 3'd0;
        iLatchPhaseUpdate = 1'b0;
        step();
        step();
        iReset_n = 1'b1;

        check("reset_state", 32'(oState), 32'd0);
        check("reset_phase", 32'(oPhase), 32'd0);
        check("reset_curdiv", oCurDiv, 32'd0);
        check("reset_comm", 32'(oCommutate), 32'd0);
        check("reset_atspeed", 32'(oAtSpeed), 32'd0);

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (oCommutate === 1'b1) seen++;
        end
        check("idle_no_comm", 32'(seen), 32'd0);
        check("idle_phase", 32'(oPhase), 32'd0);
        check("idle_state", 32'(oState), 32'd0);
        check("idle_curdiv", oCurDiv, 32'd0);

        iEnable = 1'b1;
        step();
        check("ramp_state", 32'(oState), 32'd1);
        check("ramp_curdiv", oCurDiv, 32'd10);
        waitComm(40, n);
        check("ramp_int1", 32'(n), 32'd10);
        check("ramp_div1", oCurDiv, 32'd7);
        check("ramp_phase1", 32'(oPhase), 32'd1);
        check("ramp_state1", 32'(oState), 32'd1);
        waitComm(40, n);
        check("ramp_int2", 32'(n), 32'd7);
        check("run_div", oCurDiv, 32'd4);
        check("run_state", 32'(oState), 32'd2);
        check("run_atspeed", 32'(oAtSpeed), 32'd1);
        check("run_phase2", 32'(oPhase), 32'd2);
        for (int i = 0; i < 5; i++) begin
            waitComm(40, n);
            check("cruise_int", 32'(n), 32'd4);
            check("cruise_phase", 32'(oPhase), 32'(fwdPhases[i]));
        end

        iDir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitComm(40, n);
            check("rev_int", 32'(n), 32'd4);
            check("rev_phase", 32'(oPhase), 32'(revPhases[i]));
        end

        iDir = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (oCommutate === 1'b1) seen++;
        end
        check("pre_latch_quiet", 32'(seen), 32'd0);
        iLatchPhaseUpdate = 1'b1;
        iPhaseUpdate = 3'd7;
        step();
        iLatchPhaseUpdate = 1'b0;
        iPhaseUpdate = 3'd0;
        check("latch_phase", 32'(oPhase), 32'd5);
        check("latch_no_comm", 32'(oCommutate), 32'd0);
        check("latch_div", oCurDiv, 32'd4);
        waitComm(40, n);
        check("latch_next_int", 32'(n), 32'd4);
        check("latch_next_phase", 32'(oPhase), 32'd0);

        iEnable = 1'b0;
        step();
        check("decel_state", 32'(oState), 32'd3);
        check("decel_div0", oCurDiv, 32'd4);
        waitComm(40, n);
        check("decel_int1", 32'(n), 32'd3);
        check("decel_div1", oCurDiv, 32'd7);
        check("decel_phase1", 32'(oPhase), 32'd1);
        check("decel_state1", 32'(oState), 32'd3);
        waitComm(40, n);
        check("decel_int2", 32'(n), 32'd7);
        check("stop_div", oCurDiv, 32'd10);
        check("stop_state", 32'(oState), 32'd0);
        check("stop_phase", 32'(oPhase), 32'd2);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (oCommutate === 1'b1) seen++;
        end
        check("stopped_no_comm", 32'(seen), 32'd0);
        check("stopped_phase", 32'(oPhase), 32'd2);

        iRampStep = 16'd0;
        iEnable = 1'b1;
        step();
        check("step0_state", 32'(oState), 32'd1);
        waitComm(40, n);
        check("step0_int", 32'(n), 32'd10);
        check("step0_div", oCurDiv, 32'd4);
        check("step0_state_run", 32'(oState), 32'd2);
        check("step0_atspeed", 32'(oAtSpeed), 32'd1);
        check("step0_phase", 32'(oPhase), 32'd3);

        iEnable = 1'b0;
        iReset_n = 1'b0;
        step();
        iReset_n = 1'b1;
        iRampStep = 16'd3;
        iEnable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check("midramp_state", 32'(oState), 32'd1);
        iEnable = 1'b0;
        iReset_n = 1'b0;
        step();
        iReset_n = 1'b1;
        check("midrst_state", 32'(oState), 32'd0);
        check("midrst_phase", 32'(oPhase), 32'd0);
        check("midrst_div", oCurDiv, 32'd0);
        check("midrst_comm", 32'(oCommutate), 32'd0);

        iStartDiv = 32'd0;
        iTargetDiv = 32'd0;
        iEnable = 1'b1;
        step();
        check("zero_state", 32'(oState), 32'd1);
        check("zero_div", oCurDiv, 32'd1);
        step();
        check("zero_comm_first", 32'(oCommutate), 32'd1);
        check("zero_state_run", 32'(oState), 32'd2);
        check("zero_phase_first", 32'(oPhase), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("zero_comm", 32'(oCommutate), 32'd1);
            check("zero_phase", 32'(oPhase), 32'((i + 2) % 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
